// File: rtl/breath_pkg.sv
// breath_pkg: shared types and constants for the breathing-LED PWM core.
//   ramp_state_e  ramp FSM state encoding (up / down / frozen)
//   speed_e       speed index, mapped to a ramp step by speed_step()
//   PWM_W_DEF     default PWM counter / brightness width
package breath_pkg;

  localparam int PWM_W_DEF = 8;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    RAMP_DOWN = 2'd1,
    RAMP_HOLD = 2'd2
  } ramp_state_e;

  typedef enum logic [1:0] {
    SPD_1 = 2'd0,
    SPD_2 = 2'd1,
    SPD_4 = 2'd2
  } speed_e;

  function automatic logic [2:0] speed_step(input speed_e spd);
    case (spd)
      SPD_2:   speed_step = 3'd2;
      SPD_4:   speed_step = 3'd4;
      default: speed_step = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/breath_pwm_core_edge_tick.sv
// edge_tick: rising-edge detector for a slow divider output sampled as data.
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   sig_i   slow input, treated as data
//   tick_o  one-cycle pulse on the cycle sig_i is first seen high
module edge_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic tick_o
);

  logic sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign tick_o = sig_i & ~sig_q;

endmodule

// File: rtl/breath_pwm_core.sv
// breath_pwm_core: triangle brightness ramp driving a PWM LED, with a debounced
// speed/pause button. Divider outputs arrive as plain signals in the clk domain.
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-high reset
//   clk_pwm     pwm-rate square wave (data)
//   clk_breath  ramp-rate square wave (data)
//   clk_db      debounce-rate square wave (data)
//   btn         raw button, active high, asynchronous
//   led         registered PWM output
//   brightness  current ramp value
//   dir_down    1 while descending (kept while paused)
//   paused      1 while the ramp is frozen
//
// state     | meaning
// RAMP_UP   | brightness rises by step on each breath tick
// RAMP_DOWN | brightness falls by step on each breath tick
// RAMP_HOLD | brightness frozen, dir_down remembers where to resume
module breath_pwm_core
  import breath_pkg::*;
#(
  parameter int PWM_W      = PWM_W_DEF,
  parameter int MAX_DUTY   = 255,
  parameter int DB_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_pwm,
  input  logic             clk_breath,
  input  logic             clk_db,
  input  logic             btn,
  output logic             led,
  output logic [PWM_W-1:0] brightness,
  output logic             dir_down,
  output logic             paused
);

  localparam logic [PWM_W:0]   MAX_EXT = (PWM_W+1)'(MAX_DUTY);
  localparam logic [PWM_W-1:0] MAX_VAL = PWM_W'(MAX_DUTY);

  logic pwm_tick, breath_tick, db_tick;

  edge_tick u_tick_pwm (
    .clk_i(clk), .rst_i(rst), .sig_i(clk_pwm), .tick_o(pwm_tick)
  );
  edge_tick u_tick_breath (
    .clk_i(clk), .rst_i(rst), .sig_i(clk_breath), .tick_o(breath_tick)
  );
  edge_tick u_tick_db (
    .clk_i(clk), .rst_i(rst), .sig_i(clk_db), .tick_o(db_tick)
  );

  // ---------------- button synchronizer and debounce ----------------
  logic                  btn_s1_q, btn_s2_q;
  logic [DB_SAMPLES-1:0] db_sh_q, db_sh_d;
  logic                  level_q, level_d;
  logic                  press;

  always_comb begin
    db_sh_d = db_sh_q;
    if (db_tick) db_sh_d = {db_sh_q[DB_SAMPLES-2:0], btn_s2_q};
    level_d = level_q;
    if (&db_sh_q)       level_d = 1'b1;
    else if (~|db_sh_q) level_d = 1'b0;
  end

  // Single-cycle press on the debounced 0->1 transition.
  assign press = (&db_sh_q) & ~level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      db_sh_q  <= '0;
      level_q  <= 1'b0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      db_sh_q  <= db_sh_d;
      level_q  <= level_d;
    end
  end

  // ---------------- ramp FSM ----------------
  ramp_state_e      state_q, state_d;
  speed_e           speed_q, speed_d;
  logic [PWM_W-1:0] bright_q, bright_d;
  logic             dir_q, dir_d;
  logic [PWM_W:0]   step_ext;
  logic [PWM_W:0]   sum_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RAMP_UP;
      speed_q  <= SPD_1;
      bright_q <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      bright_q <= bright_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    bright_d = bright_q;
    dir_d    = dir_q;
    step_ext = (PWM_W+1)'(speed_step(speed_q));
    // One extra bit so the sum near the ceiling cannot wrap.
    sum_ext  = {1'b0, bright_q} + step_ext;

    if (breath_tick) begin
      case (state_q)
        RAMP_UP: begin
          if (sum_ext >= MAX_EXT) begin
            bright_d = MAX_VAL;
            state_d  = RAMP_DOWN;
            dir_d    = 1'b1;
          end else begin
            bright_d = sum_ext[PWM_W-1:0];
          end
        end
        RAMP_DOWN: begin
          if ({1'b0, bright_q} <= step_ext) begin
            bright_d = '0;
            state_d  = RAMP_UP;
            dir_d    = 1'b0;
          end else begin
            bright_d = bright_q - step_ext[PWM_W-1:0];
          end
        end
        default: ;
      endcase
    end

    // A press in the same cycle as a breath tick lets the ramp use the old
    // setting; the new one is layered on top of the ramp result.
    if (press) begin
      if (state_q == RAMP_HOLD) begin
        state_d = dir_q ? RAMP_DOWN : RAMP_UP;
        speed_d = SPD_1;
      end else if (speed_q == SPD_4) begin
        state_d = RAMP_HOLD;
      end else if (speed_q == SPD_2) begin
        speed_d = SPD_4;
      end else begin
        speed_d = SPD_2;
      end
    end
  end

  always_comb begin
    paused     = (state_q == RAMP_HOLD);
    dir_down   = dir_q;
    brightness = bright_q;
  end

  // ---------------- PWM ----------------
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             led_q;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    if (pwm_tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      // Shadow takes the registered brightness, not this cycle's ramp update.
      if (pwm_cnt_q == {PWM_W{1'b1}}) duty_d = bright_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      led_q     <= (pwm_cnt_q < duty_q);
    end
  end

  assign led = led_q;

endmodule
